arith_arbiter: RTL and testbench
================================

Name: arith_arbiter

Overview:
- Shares the single combinational arithmetic unit (3add/3sub/asl/asr/2uadd/2usub) between two requesters.
- Requester 0 is the execute stage; requester 1 is the address/auxiliary path.
- Accepts operand bundles over valid/ready, arbitrates round-robin, and drives the unit with registered operands plus the enable.
- Captures the result and flags, then returns them to the winning requester over a per-requester response handshake.

Parameters:
- WIDTH, 32: operand/result width.
- CTRL_W, 3: arith_control width; encoding as decode: 010 3add, 011 3sub, 100 asl, 101 asr, 110 2uadd, 111 2usub, 000/001 unused.
- SHIFT_W, 4: shift_hex width, i.e. inst[3:0].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i is requester i
- req_ready  out  2  per-requester request accept
- req0_value1, req0_value2  in  WIDTH each  requester 0 operands
- req1_value1, req1_value2  in  WIDTH each  requester 1 operands
- req0_control, req1_control  in  CTRL_W each  operation select
- req0_shift_hex, req1_shift_hex  in  SHIFT_W each  shift amount field
- rsp_valid  out  2  per-requester result valid
- rsp_ready  in  2  per-requester result accept
- rsp_value  out  WIDTH  registered result, shared by both requesters and qualified by rsp_valid
- rsp_flags  out  2  registered flags {flags[1], flags[0]} from the unit
- arith_value1, arith_value2  out  WIDTH each  to unit
- arith_control  out  CTRL_W  to unit
- arith_shift_hex  out  SHIFT_W  to unit
- arith_en  out  1  unit enable
- arith_value_out  in  WIDTH  from unit
- arith_flags  in  2  from unit

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins first), rsp_valid=00, rsp_value=0, rsp_flags=00, arith_en=0, arith_* operand registers=0.
- State IDLE:
  - grant = the only valid requester; if both are valid, the one != last_grant.
  - req_ready[grant]=1 only in IDLE. req_ready may depend combinationally on req_valid; requesters must not make valid depend on ready.
  - On accept: latch operands/control/shift_hex into the arith_* registers, set owner=grant, last_grant=grant, go to ISSUE.
  - No valid requester: stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - arith_en=1; arith_* hold the latched operands.
  - At the clock edge, capture arith_value_out into rsp_value and arith_flags into rsp_flags, then go to RESP.
- State RESP:
  - rsp_valid[owner]=1; the other bit stays 0.
  - rsp_value and rsp_flags are held stable until rsp_ready[owner]=1.
  - On handshake: rsp_valid goes to 0 the next cycle and state goes to IDLE.
  - rsp_ready of the non-owner is ignored.
- arith_en: 0 in IDLE and RESP. arith_* values are held, not cleared, after ISSUE.
- Latency: accept at cycle N, rsp_valid high at N+2. Peak throughput is one op per 3 cycles (IDLE, ISSUE, RESP with rsp_ready already high).
- Unused controls 000/001: the op is still accepted and issued, but the arbiter forces the captured rsp_value=0 and rsp_flags=00 (flags masked).
- Requester holding rules: a request held valid while losing arbitration must keep its operands stable. The losing requester wins the next IDLE cycle in which it is valid, so there is no starvation.
- Reset mid-operation (ISSUE or RESP):
  - Next cycle state=IDLE, rsp_valid=00, arith_en=0; the in-flight result is discarded.
  - last_grant returns to 1.
- Width rules: no widening or truncation in the arbiter; carry/overflow are reported only via the unit's flags.

Decomposition:
- Shared package/header:
  - arith_control encodings (ARITH_3ADD=3'b010 ... ARITH_2USUB=3'b111).
  - State encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2).
  - WIDTH default.
- One natural sub-module: rr_arb2, a 2-way round-robin grant (inputs req_valid[1:0], last_grant; output grant, grant_any).
- The arithmetic unit stays external and is instantiated beside the arbiter by the parent.

Test Plan:
- Reset, then req0 3add value1=5, value2=7 -> req_ready[0]=1 at N, arith_en=1 at N+1, rsp_valid[0]=1 at N+2 with rsp_value=12, rsp_ready held high -> back in IDLE at N+3.
- Both valid from the first cycle after reset: req0 3sub 10-3, req1 2uadd 1+1 -> req0 served first (rsp 7), then req1 (rsp 2). Both held valid continuously -> grants alternate 0,1,0,1.
- Backpressure: rsp_ready[1]=0 for 4 cycles after rsp_valid[1] rises -> rsp_valid, rsp_value, rsp_flags stable. req0 held valid meanwhile -> req_ready[0]=0 until after the handshake.
- req0 control=000 with operands 0xFFFF_FFFF and 1 -> rsp_value=0, rsp_flags=00.
- Assert rst during ISSUE and, separately, during RESP -> next cycle rsp_valid=00, arith_en=0, state IDLE. A simultaneous req0/req1 after reset grants req0.
- Random mix of all six controls on both requesters, checked against a reference model fed the same operands: every response matches, goes to the correct owner, and no request is lost or duplicated.

Source files
------------

// File: rtl/arith_arbiter_pkg.sv
// Shared definitions for the arithmetic-unit arbiter: default widths,
// arith_control encodings and the arbiter state encoding.
package arith_arbiter_pkg;

  localparam int WIDTH_DEFAULT   = 32;
  localparam int CTRL_W_DEFAULT  = 3;
  localparam int SHIFT_W_DEFAULT = 4;

  // arith_control encodings understood by the arithmetic unit
  localparam logic [2:0] ARITH_3ADD  = 3'b010;
  localparam logic [2:0] ARITH_3SUB  = 3'b011;
  localparam logic [2:0] ARITH_ASL   = 3'b100;
  localparam logic [2:0] ARITH_ASR   = 3'b101;
  localparam logic [2:0] ARITH_2UADD = 3'b110;
  localparam logic [2:0] ARITH_2USUB = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // 000 and 001 carry no operation; every other encoding is a real op
  function automatic logic ctrl_is_op(input logic [2:0] ctrl);
    return ctrl[2] | ctrl[1];
  endfunction

endpackage

// File: rtl/arith_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie
// the requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_any
);

  assign grant_any = |req_valid;
  // With one requester valid, bit 1 tells which one it is; on a tie, alternate.
  assign grant     = (&req_valid) ? ~last_grant : req_valid[1];

endmodule

// File: rtl/arith_arbiter.sv
// Arbiter sharing one combinational arithmetic unit between the execute
// stage (requester 0) and the address/auxiliary path (requester 1).
// Flow: IDLE accepts one bundle, ISSUE drives the unit for one cycle and
// captures its result, RESP holds the result until the owner takes it.
module arith_arbiter
  import arith_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int CTRL_W  = CTRL_W_DEFAULT,
  parameter int SHIFT_W = SHIFT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req0_value1,
  input  logic [WIDTH-1:0]   req0_value2,
  input  logic [WIDTH-1:0]   req1_value1,
  input  logic [WIDTH-1:0]   req1_value2,
  input  logic [CTRL_W-1:0]  req0_control,
  input  logic [CTRL_W-1:0]  req1_control,
  input  logic [SHIFT_W-1:0] req0_shift_hex,
  input  logic [SHIFT_W-1:0] req1_shift_hex,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_value,
  output logic [1:0]         rsp_flags,
  output logic [WIDTH-1:0]   arith_value1,
  output logic [WIDTH-1:0]   arith_value2,
  output logic [CTRL_W-1:0]  arith_control,
  output logic [SHIFT_W-1:0] arith_shift_hex,
  output logic               arith_en,
  input  logic [WIDTH-1:0]   arith_value_out,
  input  logic [1:0]         arith_flags
);

  arb_state_e         r_state;
  logic               r_last_grant;
  logic               r_owner;
  logic [1:0]         r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_value;
  logic [1:0]         r_rsp_flags;
  logic [WIDTH-1:0]   r_arith_value1;
  logic [WIDTH-1:0]   r_arith_value2;
  logic [CTRL_W-1:0]  r_arith_control;
  logic [SHIFT_W-1:0] r_arith_shift_hex;
  logic               r_arith_en;

  logic               w_grant;
  logic               w_grant_any;
  logic [1:0]         w_req_ready;

  rr_arb2 u_rr_arb2 (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_any  (w_grant_any)
  );

  // Only the granted requester sees ready, and only while the unit is free.
  always_comb begin
    w_req_ready = 2'b00;
    if ((r_state == IDLE) && w_grant_any) begin
      w_req_ready[w_grant] = 1'b1;
    end
  end

  // Arbiter FSM: accept, issue for one cycle, hold the response for the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_last_grant      <= 1'b1;
      r_owner           <= 1'b0;
      r_rsp_valid       <= 2'b00;
      r_rsp_value       <= '0;
      r_rsp_flags       <= 2'b00;
      r_arith_value1    <= '0;
      r_arith_value2    <= '0;
      r_arith_control   <= '0;
      r_arith_shift_hex <= '0;
      r_arith_en        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_arith_value1    <= w_grant ? req1_value1    : req0_value1;
            r_arith_value2    <= w_grant ? req1_value2    : req0_value2;
            r_arith_control   <= w_grant ? req1_control   : req0_control;
            r_arith_shift_hex <= w_grant ? req1_shift_hex : req0_shift_hex;
            r_owner           <= w_grant;
            r_last_grant      <= w_grant;
            r_arith_en        <= 1'b1;
            r_state           <= ISSUE;
          end
        end
        ISSUE: begin
          // Unused encodings still take a slot but report a clean zero result.
          if (ctrl_is_op(r_arith_control)) begin
            r_rsp_value <= arith_value_out;
            r_rsp_flags <= arith_flags;
          end else begin
            r_rsp_value <= '0;
            r_rsp_flags <= 2'b00;
          end
          r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
          r_arith_en  <= 1'b0;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_arith_en  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready       = w_req_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_value       = r_rsp_value;
  assign rsp_flags       = r_rsp_flags;
  assign arith_value1    = r_arith_value1;
  assign arith_value2    = r_arith_value2;
  assign arith_control   = r_arith_control;
  assign arith_shift_hex = r_arith_shift_hex;
  assign arith_en        = r_arith_en;

endmodule

// File: tb/tb_arith_arbiter.sv
// Bench for arith_arbiter: a behavioural arithmetic unit sits beside the DUT,
// directed cases cover latency, ordering, backpressure, masking and reset,
// and a random phase is scored against a queue-based model.
module tb_arith_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_flags, arith_flags;
  logic [31:0] req0_value1, req0_value2, req1_value1, req1_value2;
  logic [2:0]  req0_control, req1_control, arith_control;
  logic [3:0]  req0_shift_hex, req1_shift_hex, arith_shift_hex;
  logic [31:0] rsp_value, arith_value1, arith_value2, arith_value_out;
  logic        arith_en;
  logic [33:0] unit_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arith_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_value1(req0_value1), .req0_value2(req0_value2),
    .req1_value1(req1_value1), .req1_value2(req1_value2),
    .req0_control(req0_control), .req1_control(req1_control),
    .req0_shift_hex(req0_shift_hex), .req1_shift_hex(req1_shift_hex),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_value(rsp_value), .rsp_flags(rsp_flags),
    .arith_value1(arith_value1), .arith_value2(arith_value2),
    .arith_control(arith_control), .arith_shift_hex(arith_shift_hex),
    .arith_en(arith_en),
    .arith_value_out(arith_value_out), .arith_flags(arith_flags)
  );

  // Behavioural arithmetic: returns {flags, value}
  function automatic logic [33:0] unit_f(input logic [31:0] v1, input logic [31:0] v2,
                                         input logic [2:0] c, input logic [3:0] sh);
    logic [32:0] s;
    logic [31:0] r;
    logic [1:0]  f;
    s = '0;
    case (c)
      3'b010: begin r = v1 + v2; f = {(v1[31] == v2[31]) && (r[31] != v1[31]), r == 0}; end
      3'b011: begin r = v1 - v2; f = {(v1[31] != v2[31]) && (r[31] != v1[31]), r == 0}; end
      3'b100: begin r = v1 << sh; f = {1'b0, r == 0}; end
      3'b101: begin r = $signed(v1) >>> sh; f = {1'b0, r == 0}; end
      3'b110: begin s = {1'b0, v1} + {1'b0, v2}; r = s[31:0]; f = {s[32], r == 0}; end
      3'b111: begin s = {1'b0, v1} - {1'b0, v2}; r = s[31:0]; f = {s[32], r == 0}; end
      default: begin r = v1 ^ v2; f = 2'b11; end
    endcase
    return {f, r};
  endfunction

  // Expected response seen by a requester: unused controls report zero
  function automatic logic [33:0] exp_of(input logic [31:0] v1, input logic [31:0] v2,
                                         input logic [2:0] c, input logic [3:0] sh);
    if (c[2:1] == 2'b00) return 34'd0;
    return unit_f(v1, v2, c, sh);
  endfunction

  // External unit: garbage whenever it is not enabled
  always_comb begin
    unit_out        = unit_f(arith_value1, arith_value2, arith_control, arith_shift_hex);
    arith_value_out = arith_en ? unit_out[31:0] : 32'hDEAD_BEEF;
    arith_flags     = arith_en ? unit_out[33:32] : 2'b11;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [2:0] c, input logic [3:0] sh);
    if (i == 0) begin
      req0_value1 = v1; req0_value2 = v2; req0_control = c; req0_shift_hex = sh;
    end else begin
      req1_value1 = v1; req1_value2 = v2; req1_control = c; req1_shift_hex = sh;
    end
  endtask

  task automatic wait_ready();
    int c = 0;
    while (req_ready == 2'b00 && c < 20) begin step(); c++; end
    if (c >= 20) check("timeout_req_ready", {63'd0, req_ready != 2'b00}, 64'd1);
  endtask

  task automatic wait_rsp();
    int c = 0;
    while (rsp_valid == 2'b00 && c < 20) begin step(); c++; end
    if (c >= 20) check("timeout_rsp_valid", {63'd0, rsp_valid != 2'b00}, 64'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // Random-phase model state
  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [31:0] m_v1[2], m_v2[2];
  logic [2:0]  m_c[2];
  logic [3:0]  m_sh[2];
  logic [1:0]  pend;
  logic        model_last;
  int          n_issued, n_done;

  initial begin
    logic [33:0] e;
    logic [1:0]  exp_ready;
    logic        g;
    logic [31:0] held_value;
    logic [1:0]  held_flags;

    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);

    // ---- reset state ----
    do_reset(2);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_value", rsp_value, 32'd0);
    check("rst_rsp_flags", rsp_flags, 2'b00);
    check("rst_arith_en", arith_en, 1'b0);
    check("rst_arith_v1", arith_value1, 32'd0);
    check("rst_arith_ctl", arith_control, 3'd0);
    check("rst_req_ready", req_ready, 2'b00);

    // ---- single 3add with latency ----
    set_req(0, 5, 7, 3'b010, 0); req_valid = 2'b01; #1;
    check("t1_ready_N", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00; #1;
    check("t1_en_N1", arith_en, 1'b1);
    check("t1_v1_N1", arith_value1, 32'd5);
    check("t1_v2_N1", arith_value2, 32'd7);
    check("t1_ctl_N1", arith_control, 3'b010);
    check("t1_rspv_N1", rsp_valid, 2'b00);
    step();
    e = exp_of(5, 7, 3'b010, 0);
    check("t1_rspv_N2", rsp_valid, 2'b01);
    check("t1_value_N2", rsp_value, 32'd12);
    check("t1_flags_N2", rsp_flags, e[33:32]);
    check("t1_en_N2", arith_en, 1'b0);
    step();
    check("t1_rspv_N3", rsp_valid, 2'b00);
    check("t1_hold_v1", arith_value1, 32'd5);
    req_valid = 2'b01; #1;
    check("t1_idle_N3", req_ready, 2'b01);
    req_valid = 2'b00;

    // ---- both valid from reset: alternate 0,1,0,1 ----
    do_reset(1);
    set_req(0, 10, 3, 3'b011, 0);
    set_req(1, 1, 1, 3'b110, 0);
    req_valid = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      wait_ready();
      check($sformatf("t2_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      step();
      wait_rsp();
      check($sformatf("t2_owner%0d", k), rsp_valid, (k % 2) ? 2'b10 : 2'b01);
      check($sformatf("t2_value%0d", k), rsp_value, (k % 2) ? 32'd2 : 32'd7);
      step();
    end
    req_valid = 2'b00;
    step();

    // ---- backpressure on requester 1 while requester 0 waits ----
    set_req(1, 9, 4, 3'b111, 0);
    req_valid = 2'b10; rsp_ready = 2'b01; #1;
    wait_ready();
    check("t3_grant1", req_ready, 2'b10);
    @(negedge clk);
    set_req(0, 3, 4, 3'b010, 0);
    req_valid = 2'b01; #1;
    wait_rsp();
    e = exp_of(9, 4, 3'b111, 0);
    held_value = rsp_value;
    held_flags = rsp_flags;
    check("t3_value", held_value, e[31:0]);
    check("t3_flags", held_flags, e[33:32]);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t3_stall_v%0d", j), rsp_valid, 2'b10);
      check($sformatf("t3_stall_val%0d", j), rsp_value, e[31:0]);
      check($sformatf("t3_stall_flg%0d", j), rsp_flags, e[33:32]);
      check($sformatf("t3_stall_rdy%0d", j), req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b11; #1;
    check("t3_still_resp", req_ready, 2'b00);
    step();
    check("t3_released", rsp_valid, 2'b00);
    check("t3_req0_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00; #1;
    wait_rsp();
    check("t3_req0_owner", rsp_valid, 2'b01);
    check("t3_req0_value", rsp_value, 32'd7);
    step();

    // ---- unused control is masked ----
    set_req(0, 32'hFFFF_FFFF, 1, 3'b000, 4'd3);
    req_valid = 2'b01; #1;
    wait_ready();
    @(negedge clk); req_valid = 2'b00; #1;
    check("t4_en", arith_en, 1'b1);
    wait_rsp();
    check("t4_owner", rsp_valid, 2'b01);
    check("t4_value", rsp_value, 32'd0);
    check("t4_flags", rsp_flags, 2'b00);
    step();

    // ---- reset during ISSUE ----
    set_req(0, 1, 2, 3'b010, 0);
    req_valid = 2'b01; #1;
    wait_ready();
    @(negedge clk); req_valid = 2'b00; #1;
    check("t5a_in_issue", arith_en, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("t5a_rspv", rsp_valid, 2'b00);
    check("t5a_en", arith_en, 1'b0);
    req_valid = 2'b11; #1;
    check("t5a_grant0", req_ready, 2'b01);
    req_valid = 2'b00;
    step();
    check("t5a_discard", rsp_valid, 2'b00);

    // ---- reset during RESP ----
    set_req(0, 4, 4, 3'b010, 0);
    rsp_ready = 2'b00; req_valid = 2'b01; #1;
    wait_ready();
    @(negedge clk); req_valid = 2'b00; #1;
    wait_rsp();
    check("t5b_in_resp", rsp_valid, 2'b01);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("t5b_rspv", rsp_valid, 2'b00);
    check("t5b_en", arith_en, 1'b0);
    req_valid = 2'b11; #1;
    check("t5b_grant0", req_ready, 2'b01);
    req_valid = 2'b00; rsp_ready = 2'b11;

    // ---- random mix against queue model ----
    do_reset(1);
    pend = 2'b00; model_last = 1'b1; n_issued = 0; n_done = 0;
    for (int cyc = 0; cyc < 2700; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && cyc < 2500 && $urandom_range(0, 2) == 0) begin
          m_v1[i] = $urandom; m_v2[i] = $urandom;
          if ($urandom_range(0, 3) == 0) m_v2[i] = m_v1[i];
          m_c[i] = 3'($urandom_range(0, 7)); m_sh[i] = 4'($urandom_range(0, 15));
          set_req(i, m_v1[i], m_v2[i], m_c[i], m_sh[i]);
          pend[i] = 1'b1;
        end
      end
      req_valid = pend;
      rsp_ready = (cyc < 2500) ? 2'($urandom_range(0, 3)) : 2'b11;
      #1;
      // unit is free only when nothing is outstanding
      exp_ready = 2'b00;
      if (q0.size() == 0 && q1.size() == 0 && pend != 2'b00) begin
        g = (pend == 2'b11) ? ~model_last : pend[1];
        exp_ready = g ? 2'b10 : 2'b01;
      end
      check("rand_req_ready", req_ready, exp_ready);
      if (req_ready != 2'b00) begin
        g = req_ready[1];
        e = exp_of(m_v1[g], m_v2[g], m_c[g], m_sh[g]);
        if (g) q1.push_back(e); else q0.push_back(e);
        pend[g] = 1'b0;
        model_last = g;
        n_issued++;
      end
      if (rsp_valid != 2'b00) begin
        check("rand_rsp_onehot", {63'd0, rsp_valid == 2'b01 || rsp_valid == 2'b10}, 64'd1);
        check("rand_rsp_owner", {63'd0, rsp_valid[1] ? (q1.size() != 0) : (q0.size() != 0)}, 64'd1);
      end
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if ((i == 0 && q0.size() != 0) || (i == 1 && q1.size() != 0)) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rand_value_r%0d", i), rsp_value, e[31:0]);
            check($sformatf("rand_flags_r%0d", i), rsp_flags, e[33:32]);
            n_done++;
          end
        end
      end
    end
    check("rand_drained", {63'd0, pend == 2'b00 && q0.size() == 0 && q1.size() == 0}, 64'd1);
    check("rand_count", n_done, n_issued);
    check("rand_activity", {63'd0, n_issued > 100}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
